pool2_flatten_buffer: RTL

// - Downstream neighbour of the Pool2 datapath. Captures the NUMBER_OF_UNITS parallel pooled outputs
//   (one word per lane per in_valid strobe) into lane-banked on-chip RAM.
// - Once all IFM_DEPTH maps are complete, streams them to the FC1 stage as one flattened vector
//   (map-major, pixel-minor) over a valid/ready handshake at up to 1 word/cycle.

---
 rtl/pool2_flatten_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/pool2_flatten_buffer.sv
// pool2_flatten_buffer: banks Pool2 lane outputs in RAM, then streams them map-major to FC1
module pool2_flatten_buffer #(
   parameter int DATA_WIDTH      = 32,
   parameter int IFM_SIZE_NEXT   = 5,
   parameter int IFM_DEPTH       = 6,
   parameter int NUMBER_OF_UNITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   input  logic [DATA_WIDTH-1:0] data_in_2,
   input  logic [DATA_WIDTH-1:0] data_in_3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int PIX    = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
   localparam int GROUPS = IFM_DEPTH / NUMBER_OF_UNITS;
   localparam int WORDS  = GROUPS * PIX;
   localparam int PW = PIX > 1 ? $clog2(PIX) : 1;
   localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
   localparam int LW = NUMBER_OF_UNITS > 1 ? $clog2(NUMBER_OF_UNITS) : 1;
   localparam int AW = WORDS > 1 ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, STREAM} state_t;
   state_t state, state_n;

   logic [DATA_WIDTH-1:0] bank [NUMBER_OF_UNITS][WORDS];
   logic [DATA_WIDTH-1:0] lane_in [3];
   logic [PW-1:0] pix;
   logic [GW-1:0] g;
   logic [LW-1:0] lane;
   logic [AW-1:0] addr;
   logic pix_end, g_end, lane_end, collect_wr, accept_last, fetch;

   assign lane_in[0]  = data_in_1;
   assign lane_in[1]  = data_in_2;
   assign lane_in[2]  = data_in_3;
   assign addr        = AW'(g) * AW'(PIX) + AW'(pix);
   assign pix_end     = pix == PW'(PIX - 1);
   assign g_end       = g == GW'(GROUPS - 1);
   assign lane_end    = lane == LW'(NUMBER_OF_UNITS - 1);
   assign collect_wr  = state == COLLECT && in_valid && !start;
   assign accept_last = out_valid && out_ready && out_last;
   // the last word already loaded means nothing more to fetch, even when the sink is ready
   assign fetch       = state == STREAM && (!out_valid || out_ready) && !(out_valid && out_last);
   assign busy        = state != IDLE;

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;

   // next state: start overrides everything; collection ends on the final write, stream on the final accept
   always_comb begin
      state_n = state;
      if (start) state_n = COLLECT;
      else if (collect_wr && g_end && pix_end) state_n = STREAM;
      else if (state == STREAM && accept_last) state_n = IDLE;
   end

   // lane banks: every collected beat writes all lanes at the same address
   always_ff @(posedge clk)
      if (collect_wr)
         for (int u = 0; u < NUMBER_OF_UNITS; u++) bank[u][addr] <= lane_in[u];

   // counters, output register and status flags
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         pix       <= '0;
         g         <= '0;
         lane      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            pix       <= '0;
            g         <= '0;
            lane      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
         end else begin
            if (in_valid && state != COLLECT) err <= 1'b1;
            if (collect_wr) begin
               pix <= pix_end ? '0 : pix + 1'b1;
               if (pix_end) g <= g_end ? '0 : g + 1'b1;
            end
            if (state == STREAM && accept_last) begin
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               done      <= 1'b1;
            end else if (fetch) begin
               out_data  <= bank[lane][addr];
               out_valid <= 1'b1;
               out_last  <= g_end && lane_end && pix_end;
               pix       <= pix_end ? '0 : pix + 1'b1;
               if (pix_end) begin
                  lane <= lane_end ? '0 : lane + 1'b1;
                  if (lane_end) g <= g_end ? '0 : g + 1'b1;
               end
            end
         end
      end
endmodule
